// File: rtl/rvfi_check_pkg.sv
// Shared encodings for the RVFI shadow-state checker: error causes and FSM states.
package rvfi_check_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    PC    = 3'd1,
    RS1   = 3'd2,
    RS2   = 3'd3,
    ORDER = 3'd4,
    X0    = 3'd5,
    GAP   = 3'd6
  } err_code_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERR   = 2'd2
  } state_e;

endpackage

// File: rtl/rvfi_shadow_regfile.sv
// Shadow x1..x31 with known bits. Read ports see learns and writes of lower slots
// in the same cycle; the whole cycle's view is committed only when commit_i is set.
module rvfi_shadow_regfile
  import rvfi_check_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NRET = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       commit_i,
  input  logic [NRET-1:0]            slot_en_i,
  input  logic [NRET-1:0]            wr_en_i,
  input  logic [NRET-1:0][4:0]       rs1_addr_i,
  input  logic [NRET-1:0][4:0]       rs2_addr_i,
  input  logic [NRET-1:0][4:0]       rd_addr_i,
  input  logic [NRET-1:0][XLEN-1:0]  rs1_rdata_i,
  input  logic [NRET-1:0][XLEN-1:0]  rs2_rdata_i,
  input  logic [NRET-1:0][XLEN-1:0]  rd_wdata_i,
  output logic [NRET-1:0]            rs1_known_o,
  output logic [NRET-1:0]            rs2_known_o,
  output logic [NRET-1:0][XLEN-1:0]  rs1_val_o,
  output logic [NRET-1:0][XLEN-1:0]  rs2_val_o
);

  logic [XLEN-1:0]        rf_q [1:31];
  logic [31:1]            kn_q;
  logic [31:0][XLEN-1:0]  vw_val;
  logic [31:0]            vw_kn;

  // Slots are walked in order, so a higher slot's write overwrites a lower one's.
  always_comb begin
    vw_val      = '0;
    vw_kn       = '0;
    rs1_val_o   = '0;
    rs2_val_o   = '0;
    rs1_known_o = '0;
    rs2_known_o = '0;
    for (int i = 1; i < 32; i++) begin
      vw_val[i] = rf_q[i];
      vw_kn[i]  = kn_q[i];
    end
    for (int k = 0; k < NRET; k++) begin
      rs1_val_o[k]   = vw_val[rs1_addr_i[k]];
      rs1_known_o[k] = vw_kn[rs1_addr_i[k]];
      if (slot_en_i[k] && rs1_addr_i[k] != 5'd0 && !vw_kn[rs1_addr_i[k]]) begin
        vw_val[rs1_addr_i[k]] = rs1_rdata_i[k];
        vw_kn[rs1_addr_i[k]]  = 1'b1;
      end
      rs2_val_o[k]   = vw_val[rs2_addr_i[k]];
      rs2_known_o[k] = vw_kn[rs2_addr_i[k]];
      if (slot_en_i[k] && rs2_addr_i[k] != 5'd0 && !vw_kn[rs2_addr_i[k]]) begin
        vw_val[rs2_addr_i[k]] = rs2_rdata_i[k];
        vw_kn[rs2_addr_i[k]]  = 1'b1;
      end
      if (slot_en_i[k] && wr_en_i[k] && rd_addr_i[k] != 5'd0) begin
        vw_val[rd_addr_i[k]] = rd_wdata_i[k];
        vw_kn[rd_addr_i[k]]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) rf_q[i] <= '0;
      kn_q <= '0;
    end else if (commit_i) begin
      for (int i = 1; i < 32; i++) begin
        rf_q[i] <= vw_val[i];
        kn_q[i] <= vw_kn[i];
      end
    end
  end

endmodule

// File: rtl/rvfi_shadow_state_checker.sv
// Checks an NRET-wide RVFI retire stream against shadow register/PC/order state;
// the first violation is latched and the checker then freezes until reset.
module rvfi_shadow_state_checker
  import rvfi_check_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NRET    = 1,
  parameter int ORDER_W = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NRET-1:0]           rvfi_valid,
  input  logic [NRET*ORDER_W-1:0]   rvfi_order,
  input  logic [NRET-1:0]           rvfi_trap,
  input  logic [NRET*XLEN-1:0]      rvfi_pc_rdata,
  input  logic [NRET*XLEN-1:0]      rvfi_pc_wdata,
  input  logic [NRET*5-1:0]         rvfi_rs1_addr,
  input  logic [NRET*5-1:0]         rvfi_rs2_addr,
  input  logic [NRET*XLEN-1:0]      rvfi_rs1_rdata,
  input  logic [NRET*XLEN-1:0]      rvfi_rs2_rdata,
  input  logic [NRET*5-1:0]         rvfi_rd_addr,
  input  logic [NRET*XLEN-1:0]      rvfi_rd_wdata,
  output logic                      err,
  output logic [2:0]                err_code,
  output logic [$clog2(NRET):0]     err_chan,
  output logic [ORDER_W-1:0]        err_order,
  output logic [ORDER_W-1:0]        retired
);

  localparam int CHW = $clog2(NRET) + 1;

  logic [NRET-1:0][ORDER_W-1:0] order;
  logic [NRET-1:0][XLEN-1:0]    pc_rd, pc_wd, rs1_rd, rs2_rd, rd_wd;
  logic [NRET-1:0][4:0]         rs1_a, rs2_a, rd_a;
  logic [NRET-1:0]              rs1_kn, rs2_kn, wr_en;
  logic [NRET-1:0][XLEN-1:0]    rs1_val, rs2_val;

  assign order  = rvfi_order;
  assign pc_rd  = rvfi_pc_rdata;
  assign pc_wd  = rvfi_pc_wdata;
  assign rs1_rd = rvfi_rs1_rdata;
  assign rs2_rd = rvfi_rs2_rdata;
  assign rd_wd  = rvfi_rd_wdata;
  assign rs1_a  = rvfi_rs1_addr;
  assign rs2_a  = rvfi_rs2_addr;
  assign rd_a   = rvfi_rd_addr;

  state_e               state_q;
  logic [XLEN-1:0]      pc_q, pc_d;
  logic                 pc_known_q, pc_known_d;
  logic [ORDER_W-1:0]   exp_order_q, retired_q, base_order, n_vld;
  logic                 err_q;
  err_code_e            err_code_q, cause;
  logic [CHW-1:0]       err_chan_q, cause_chan;
  logic [ORDER_W-1:0]   err_order_q, cause_order;
  logic                 any_vld, commit;

  function automatic logic rs_ok(input logic [4:0] a, input logic [XLEN-1:0] d,
                                 input logic kn, input logic [XLEN-1:0] v);
    if (a == 5'd0) return d == '0;
    return !kn || (v == d);
  endfunction

  rvfi_shadow_regfile #(.XLEN(XLEN), .NRET(NRET)) u_rf (
    .clock       (clock),
    .reset       (reset),
    .commit_i    (commit),
    .slot_en_i   (rvfi_valid),
    .wr_en_i     (wr_en),
    .rs1_addr_i  (rs1_a),
    .rs2_addr_i  (rs2_a),
    .rd_addr_i   (rd_a),
    .rs1_rdata_i (rs1_rd),
    .rs2_rdata_i (rs2_rd),
    .rd_wdata_i  (rd_wd),
    .rs1_known_o (rs1_kn),
    .rs2_known_o (rs2_kn),
    .rs1_val_o   (rs1_val),
    .rs2_val_o   (rs2_val)
  );

  assign any_vld = |rvfi_valid;

  // PC expectation ripples through the slots; the first (lowest slot) cause is kept.
  always_comb begin
    err_code_e slot_code;
    logic      gap;
    base_order  = (state_q == IDLE) ? order[0] : exp_order_q;
    pc_d        = pc_q;
    pc_known_d  = pc_known_q;
    cause       = NONE;
    cause_chan  = '0;
    cause_order = '0;
    n_vld       = '0;
    wr_en       = '0;
    gap         = 1'b0;
    for (int k = 0; k < NRET; k++) begin
      slot_code = NONE;
      if (!rvfi_valid[k]) begin
        gap = 1'b1;
      end else begin
        if (pc_known_d && pc_rd[k] != pc_d)                          slot_code = PC;
        else if (!rs_ok(rs1_a[k], rs1_rd[k], rs1_kn[k], rs1_val[k])) slot_code = RS1;
        else if (!rs_ok(rs2_a[k], rs2_rd[k], rs2_kn[k], rs2_val[k])) slot_code = RS2;
        else if (order[k] != base_order + ORDER_W'(k))               slot_code = ORDER;
        else if (rd_a[k] == 5'd0 && rd_wd[k] != '0)                  slot_code = X0;
        else if (gap)                                                slot_code = GAP;
        if (slot_code != NONE && cause == NONE) begin
          cause       = slot_code;
          cause_chan  = CHW'(k);
          cause_order = order[k];
        end
        n_vld    = n_vld + ORDER_W'(1);
        wr_en[k] = !rvfi_trap[k];
        if (rvfi_trap[k]) begin
          pc_known_d = 1'b0;
        end else begin
          pc_d       = pc_wd[k];
          pc_known_d = 1'b1;
        end
      end
    end
  end

  assign commit = (state_q != ERR) && any_vld && (cause == NONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      pc_known_q  <= 1'b0;
      exp_order_q <= '0;
      retired_q   <= '0;
      err_q       <= 1'b0;
      err_code_q  <= NONE;
      err_chan_q  <= '0;
      err_order_q <= '0;
    end else if (state_q != ERR && any_vld) begin
      if (cause != NONE) begin
        state_q     <= ERR;
        err_q       <= 1'b1;
        err_code_q  <= cause;
        err_chan_q  <= cause_chan;
        err_order_q <= cause_order;
      end else begin
        state_q     <= TRACK;
        exp_order_q <= base_order + n_vld;
        retired_q   <= retired_q + n_vld;
        pc_q        <= pc_d;
        pc_known_q  <= pc_known_d;
      end
    end
  end

  assign err       = err_q;
  assign err_code  = err_code_q;
  assign err_chan  = err_chan_q;
  assign err_order = err_order_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_rvfi_shadow_state_checker.sv
// Randomized and directed bench for the RVFI shadow-state checker, compared each
// cycle against an array-based reference model of the retire rules.
module tb_rvfi_shadow_state_checker;
  localparam int XLEN = 32;
  localparam int NRET = 2;
  localparam int OW   = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NRET-1:0]           valid, trap;
  logic [NRET-1:0][OW-1:0]   order;
  logic [NRET-1:0][XLEN-1:0] pc_r, pc_w, rs1_d, rs2_d, rd_d;
  logic [NRET-1:0][4:0]      rs1_a, rs2_a, rd_a;
  logic                      err;
  logic [2:0]                err_code;
  logic [1:0]                err_chan;
  logic [OW-1:0]             err_order, retired;

  rvfi_shadow_state_checker #(.XLEN(XLEN), .NRET(NRET), .ORDER_W(OW)) dut (
    .clock(clk), .reset(rst), .rvfi_valid(valid), .rvfi_order(order), .rvfi_trap(trap),
    .rvfi_pc_rdata(pc_r), .rvfi_pc_wdata(pc_w), .rvfi_rs1_addr(rs1_a), .rvfi_rs2_addr(rs2_a),
    .rvfi_rs1_rdata(rs1_d), .rvfi_rs2_rdata(rs2_d), .rvfi_rd_addr(rd_a), .rvfi_rd_wdata(rd_d),
    .err(err), .err_code(err_code), .err_chan(err_chan), .err_order(err_order), .retired(retired)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;

  // reference model: 0 = waiting for first retire, 1 = tracking, 2 = error latched
  int          m_st;
  logic [31:0] m_rf [32];
  bit          m_kn [32];
  logic [31:0] m_pc;
  bit          m_pck;
  logic [63:0] m_exp, m_ret, m_eord;
  bit          m_err;
  logic [2:0]  m_code;
  logic [1:0]  m_chan;

  // stimulus generator's view of the true architectural state
  logic [31:0] g_rf [32];
  logic [31:0] g_pc;
  logic [63:0] g_order;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pc = '0; m_pck = 0; m_exp = '0; m_ret = '0; m_eord = '0;
    m_err = 0; m_code = '0; m_chan = '0;
    for (int i = 0; i < 32; i++) begin m_rf[i] = '0; m_kn[i] = 0; end
  endtask

  task automatic model_step();
    logic [31:0] rf [32];
    bit          kn [32];
    logic [31:0] pc;
    bit          pck, gap, found, ok1, ok2;
    logic [63:0] base, n;
    int          c;
    if (m_st == 2 || valid == '0) return;
    rf = m_rf; kn = m_kn; pc = m_pc; pck = m_pck;
    base = (m_st == 0) ? order[0] : m_exp;
    gap = 0; found = 0; n = '0;
    for (int k = 0; k < NRET; k++) begin
      if (!valid[k]) begin gap = 1; continue; end
      if (rs1_a[k] == 0) ok1 = (rs1_d[k] == 0);
      else if (kn[rs1_a[k]]) ok1 = (rf[rs1_a[k]] == rs1_d[k]);
      else begin ok1 = 1; kn[rs1_a[k]] = 1; rf[rs1_a[k]] = rs1_d[k]; end
      if (rs2_a[k] == 0) ok2 = (rs2_d[k] == 0);
      else if (kn[rs2_a[k]]) ok2 = (rf[rs2_a[k]] == rs2_d[k]);
      else begin ok2 = 1; kn[rs2_a[k]] = 1; rf[rs2_a[k]] = rs2_d[k]; end
      if (pck && pc_r[k] != pc)                  c = 1;
      else if (!ok1)                             c = 2;
      else if (!ok2)                             c = 3;
      else if (order[k] != base + 64'(k))        c = 4;
      else if (rd_a[k] == 0 && rd_d[k] != 0)     c = 5;
      else if (gap)                              c = 6;
      else                                       c = 0;
      if (c != 0 && !found) begin
        found = 1; m_code = 3'(c); m_chan = 2'(k); m_eord = order[k];
      end
      n = n + 1;
      if (!trap[k] && rd_a[k] != 0) begin rf[rd_a[k]] = rd_d[k]; kn[rd_a[k]] = 1; end
      if (trap[k]) pck = 0;
      else begin pc = pc_w[k]; pck = 1; end
    end
    if (found) begin
      m_st = 2; m_err = 1;
    end else begin
      m_st = 1; m_rf = rf; m_kn = kn; m_pc = pc; m_pck = pck;
      m_exp = base + n; m_ret = m_ret + n;
    end
  endtask

  task automatic compare();
    vectors++;
    chk("err", 64'(err), 64'(m_err));
    chk("err_code", 64'(err_code), 64'(m_code));
    chk("err_chan", 64'(err_chan), 64'(m_chan));
    chk("err_order", err_order, m_eord);
    chk("retired", retired, m_ret);
  endtask

  task automatic clear_in();
    valid = '0; trap = '0; order = '0; pc_r = '0; pc_w = '0;
    rs1_a = '0; rs2_a = '0; rd_a = '0; rs1_d = '0; rs2_d = '0; rd_d = '0;
  endtask

  task automatic set_slot(input int k, input logic [63:0] o, input logic [31:0] pc, input logic [31:0] pcw,
                          input logic [4:0] a1, input logic [31:0] d1, input logic [4:0] a2,
                          input logic [31:0] d2, input logic [4:0] rd, input logic [31:0] wd, input bit tr);
    valid[k] = 1'b1; order[k] = o; pc_r[k] = pc; pc_w[k] = pcw;
    rs1_a[k] = a1; rs1_d[k] = d1; rs2_a[k] = a2; rs2_d[k] = d2;
    rd_a[k] = rd; rd_d[k] = wd; trap[k] = tr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    compare();
    @(negedge clk);
    clear_in();
  endtask

  // reset is raised between clock edges to exercise the asynchronous path
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 model_reset();
    compare();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic gen_slot(input int k);
    logic [4:0]  a1, a2, rd;
    logic [31:0] wd, pcw, nxt;
    bit          tr;
    a1 = 5'($urandom_range(0, 31));
    a2 = 5'($urandom_range(0, 31));
    rd = 5'($urandom_range(0, 31));
    wd = (rd == 0) ? 32'h0 : $urandom;
    tr = ($urandom_range(0, 15) == 0);
    nxt = $urandom & 32'hFFFF_FFFC;
    pcw = ($urandom_range(0, 7) == 0) ? nxt : g_pc + 32'd4;
    set_slot(k, g_order, g_pc, pcw, a1, g_rf[a1], a2, g_rf[a2], rd, wd, tr);
    g_order = g_order + 1;
    if (!tr && rd != 0) g_rf[rd] = wd;
    g_pc = tr ? nxt : pcw;
  endtask

  initial begin
    clear_in();
    model_reset();
    do_reset();
    chk("reset err", 64'(err), 64'd0);
    chk("reset retired", retired, 64'd0);
    chk("reset err_order", err_order, 64'd0);

    // write x5 then read it back correctly
    set_slot(0, 64'd0, 32'h100, 32'h104, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 32'h1234, 1'b0); step();
    set_slot(0, 64'd1, 32'h104, 32'h108, 5'd5, 32'h1234, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0); step();
    chk("rd fwd err", 64'(err), 64'd0);
    chk("rd fwd retired", retired, 64'd2);

    // wrong rs1 value, then frozen outputs
    do_reset();
    set_slot(0, 64'd0, 32'h100, 32'h104, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 32'h1234, 1'b0); step();
    set_slot(0, 64'd1, 32'h104, 32'h108, 5'd5, 32'h1235, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0); step();
    chk("rs1 err", 64'(err), 64'd1);
    chk("rs1 code", 64'(err_code), 64'd2);
    chk("rs1 chan", 64'(err_chan), 64'd0);
    chk("rs1 order", err_order, 64'd1);
    for (int i = 0; i < 10; i++) begin
      set_slot(0, 64'($urandom), $urandom, $urandom, 5'd1, $urandom, 5'd2, $urandom, 5'd0, $urandom, 1'b0);
      step();
    end
    chk("frozen code", 64'(err_code), 64'd2);
    chk("frozen retired", retired, 64'd1);

    // same-cycle forwarding between slots
    do_reset();
    set_slot(0, 64'd0, 32'h100, 32'h104, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 32'hA, 1'b0);
    set_slot(1, 64'd1, 32'h104, 32'h108, 5'd0, 32'h0, 5'd7, 32'hA, 5'd0, 32'h0, 1'b0); step();
    chk("fwd ok err", 64'(err), 64'd0);
    chk("fwd ok retired", retired, 64'd2);
    set_slot(0, 64'd2, 32'h108, 32'h10C, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 32'hA, 1'b0);
    set_slot(1, 64'd3, 32'h10C, 32'h110, 5'd0, 32'h0, 5'd7, 32'hB, 5'd0, 32'h0, 1'b0); step();
    chk("fwd bad code", 64'(err_code), 64'd3);
    chk("fwd bad chan", 64'(err_chan), 64'd1);
    chk("fwd bad order", err_order, 64'd3);

    // slot gap
    do_reset();
    set_slot(1, 64'd1, 32'h100, 32'h104, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0); step();
    chk("gap code", 64'(err_code), 64'd6);
    chk("gap chan", 64'(err_chan), 64'd1);

    // order jump
    do_reset();
    set_slot(0, 64'd3, 32'h100, 32'h104, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0); step();
    set_slot(0, 64'd5, 32'h104, 32'h108, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0); step();
    chk("order code", 64'(err_code), 64'd4);
    chk("order order", err_order, 64'd5);

    // trap drops PC knowledge and the rd write
    do_reset();
    set_slot(0, 64'd0, 32'h200, 32'h204, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 32'h55, 1'b1); step();
    set_slot(0, 64'd1, 32'h8000_0000, 32'h8000_0004, 5'd9, 32'h77, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0); step();
    set_slot(0, 64'd2, 32'h8000_0004, 32'h8000_0008, 5'd0, 32'h0, 5'd9, 32'h77, 5'd0, 32'h0, 1'b0); step();
    chk("trap err", 64'(err), 64'd0);
    chk("trap retired", retired, 64'd3);

    // order wrap, then x0 write
    do_reset();
    set_slot(0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h10, 32'h14, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    set_slot(1, 64'd0, 32'h14, 32'h18, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0); step();
    set_slot(0, 64'd1, 32'h18, 32'h1C, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0); step();
    chk("wrap err", 64'(err), 64'd0);
    chk("wrap retired", retired, 64'd3);
    set_slot(0, 64'd2, 32'h1C, 32'h20, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h1, 1'b0); step();
    chk("x0 code", 64'(err_code), 64'd5);

    // reset out of ERR, new base order
    do_reset();
    chk("rst err", 64'(err), 64'd0);
    set_slot(0, 64'h40, 32'h300, 32'h304, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0); step();
    chk("rebase err", 64'(err), 64'd0);
    chk("rebase retired", retired, 64'd1);
    set_slot(0, 64'h41, 32'h304, 32'h308, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0); step();
    chk("rebase next", retired, 64'd2);

    // randomized episodes with occasional faults
    for (int ep = 0; ep < 40; ep++) begin
      int r;
      int f;
      do_reset();
      g_order = (ep % 4 == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 : {$urandom, $urandom};
      g_pc = $urandom & 32'hFFFF_FFFC;
      for (int i = 0; i < 32; i++) g_rf[i] = (i == 0) ? 32'h0 : $urandom;
      for (int cy = 0; cy < 50; cy++) begin
        r = $urandom_range(0, 9);
        if (r >= 3) gen_slot(0);
        if (r >= 6) gen_slot(1);
        if (valid[0] && $urandom_range(0, 29) == 0) begin
          f = $urandom_range(0, 4);
          case (f)
            0: pc_r[0] = pc_r[0] ^ 32'h4;
            1: rs1_d[0] = rs1_d[0] ^ 32'h1;
            2: order[0] = order[0] + 64'd1;
            3: begin rd_a[0] = 5'd0; rd_d[0] = 32'h1; end
            default: valid[0] = 1'b0;
          endcase
        end
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
